// File: rtl/bram_slave_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bram_slave_port : bit-serial slave port in front of a 2**ADDR_LEN x DATA_LEN
// synchronous RAM. Optional macro BRAM_SLAVE_DELAY_EN adds the read WAIT state.
// Rev 1.0
// ---------------------------------------------------------------------------
module bram_slave_port #(
   parameter int ADDR_LEN  = 12,
   parameter int DATA_LEN  = 8,
   parameter int BURST_LEN = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_read_en,
   input  logic       s_write_en,
   input  logic       s_master_valid,
   input  logic       s_master_ready,
   input  logic       s_rx_address,
   input  logic       s_rx_burst,
   input  logic       s_rx_data,
   input  logic [5:0] s_slave_delay,
   output logic       s_slave_ready,
   output logic       s_slave_valid,
   output logic       s_tx_data,
   output logic       s_split_en
);

   localparam int MAX_LEN = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
   localparam int CNT_W   = $clog2(MAX_LEN + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      WDATA = 3'd2,
      FETCH = 3'd3,
`ifdef BRAM_SLAVE_DELAY_EN
      WAIT  = 3'd4,
`endif
      RDATA = 3'd5
   } state_t;

   state_t                state;
   logic [ADDR_LEN-1:0]   addr_q;
   logic [BURST_LEN-1:0]  burst_q;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  is_wr;
   logic [DATA_LEN-1:0]   shift_q;
   logic                  wr_pend;
   logic [DATA_LEN-1:0]   wr_word;
   logic [ADDR_LEN-1:0]   wr_addr;
   logic                  last_beat;

   logic [DATA_LEN-1:0]   mem [2**ADDR_LEN];

`ifdef BRAM_SLAVE_DELAY_EN
   logic [5:0]            dly_q;
   logic [5:0]            wait_cnt;
`else
   logic                  unused_delay;
   assign unused_delay = ^s_slave_delay;
`endif

   // burst_q counts remaining beats; a count of 0 behaves like 1
   assign last_beat  = (burst_q <= BURST_LEN'(1));
   assign s_tx_data  = shift_q[0];
   assign s_split_en = 1'b0;

   // Completed write words land in the RAM one edge after their last bit
   always_ff @(posedge clk) begin
      if (wr_pend) begin
         mem[wr_addr] <= wr_word;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         addr_q        <= '0;
         burst_q       <= '0;
         bit_cnt       <= '0;
         is_wr         <= 1'b0;
         shift_q       <= '0;
         wr_pend       <= 1'b0;
         wr_word       <= '0;
         wr_addr       <= '0;
         s_slave_ready <= 1'b1;
         s_slave_valid <= 1'b0;
`ifdef BRAM_SLAVE_DELAY_EN
         dly_q         <= '0;
         wait_cnt      <= '0;
`endif
      end else begin
         wr_pend <= 1'b0;
         case (state)
            IDLE: begin
               if (s_master_valid && (s_read_en ^ s_write_en)) begin
                  addr_q        <= {s_rx_address, addr_q[ADDR_LEN-1:1]};
                  burst_q       <= BURST_LEN'(s_rx_burst);
                  bit_cnt       <= CNT_W'(1);
                  is_wr         <= s_write_en;
                  s_slave_ready <= 1'b0;
                  state         <= ADDR;
`ifdef BRAM_SLAVE_DELAY_EN
                  dly_q         <= s_slave_delay;
`endif
               end
            end

            ADDR: begin
               if (s_master_valid) begin
                  addr_q  <= {s_rx_address, addr_q[ADDR_LEN-1:1]};
                  burst_q <= burst_q | (BURST_LEN'(s_rx_burst) << bit_cnt);
                  if (bit_cnt == CNT_W'(ADDR_LEN - 1)) begin
                     bit_cnt <= '0;
                     state   <= is_wr ? WDATA : FETCH;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end

            WDATA: begin
               if (s_master_valid) begin
                  shift_q <= {s_rx_data, shift_q[DATA_LEN-1:1]};
                  if (bit_cnt == CNT_W'(DATA_LEN - 1)) begin
                     bit_cnt <= '0;
                     wr_word <= {s_rx_data, shift_q[DATA_LEN-1:1]};
                     wr_addr <= addr_q;
                     wr_pend <= 1'b1;
                     addr_q  <= addr_q + ADDR_LEN'(1);
                     if (last_beat) begin
                        state         <= IDLE;
                        s_slave_ready <= 1'b1;
                     end else begin
                        burst_q <= burst_q - BURST_LEN'(1);
                     end
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end

            FETCH: begin
               shift_q <= mem[addr_q];
               bit_cnt <= '0;
`ifdef BRAM_SLAVE_DELAY_EN
               if (dly_q != 6'd0) begin
                  wait_cnt <= dly_q;
                  state    <= WAIT;
               end else begin
                  state         <= RDATA;
                  s_slave_valid <= 1'b1;
               end
`else
               state         <= RDATA;
               s_slave_valid <= 1'b1;
`endif
            end

`ifdef BRAM_SLAVE_DELAY_EN
            WAIT: begin
               if (wait_cnt == 6'd1) begin
                  state         <= RDATA;
                  s_slave_valid <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 6'd1;
               end
            end
`endif

            RDATA: begin
               if (s_master_ready) begin
                  shift_q <= {1'b0, shift_q[DATA_LEN-1:1]};
                  if (bit_cnt == CNT_W'(DATA_LEN - 1)) begin
                     bit_cnt       <= '0;
                     addr_q        <= addr_q + ADDR_LEN'(1);
                     s_slave_valid <= 1'b0;
                     if (last_beat) begin
                        state         <= IDLE;
                        s_slave_ready <= 1'b1;
                     end else begin
                        burst_q <= burst_q - BURST_LEN'(1);
                        state   <= FETCH;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end

            default: begin
               state         <= IDLE;
               s_slave_ready <= 1'b1;
               s_slave_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bram_slave_port.sv
`default_nettype none
// tb_bram_slave_port : directed + randomized bench, RAM contents tracked by a plain array model.
module tb_bram_slave_port;

   localparam int AW    = 12;
   localparam int DW    = 8;
   localparam int BW    = 12;
   localparam int DEPTH = 1 << AW;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s_read_en = 1'b0;
   logic       s_write_en = 1'b0;
   logic       s_master_valid = 1'b0;
   logic       s_master_ready = 1'b0;
   logic       s_rx_address = 1'b0;
   logic       s_rx_burst = 1'b0;
   logic       s_rx_data = 1'b0;
   logic [5:0] s_slave_delay = 6'd0;
   logic       s_slave_ready;
   logic       s_slave_valid;
   logic       s_tx_data;
   logic       s_split_en;

   always #5 clk = ~clk;

   bram_slave_port #(.ADDR_LEN(AW), .DATA_LEN(DW), .BURST_LEN(BW)) dut (
      .clk            (clk),
      .rst            (rst),
      .s_read_en      (s_read_en),
      .s_write_en     (s_write_en),
      .s_master_valid (s_master_valid),
      .s_master_ready (s_master_ready),
      .s_rx_address   (s_rx_address),
      .s_rx_burst     (s_rx_burst),
      .s_rx_data      (s_rx_data),
      .s_slave_delay  (s_slave_delay),
      .s_slave_ready  (s_slave_ready),
      .s_slave_valid  (s_slave_valid),
      .s_tx_data      (s_tx_data),
      .s_split_en     (s_split_en)
   );

   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] wbuf [8];
   logic          bits_q [64];
   int            checks = 0;
   int            errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // random pauses with junk on every master line
   task automatic gap();
      while ($urandom_range(0, 3) == 0) begin
         s_master_valid = 1'b0;
         s_rx_address   = 1'($urandom_range(0, 1));
         s_rx_burst     = 1'($urandom_range(0, 1));
         s_rx_data      = 1'($urandom_range(0, 1));
         s_read_en      = 1'($urandom_range(0, 1));
         s_write_en     = 1'($urandom_range(0, 1));
         cyc();
      end
   endtask

   task automatic start_txn(input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] b,
                            input logic [5:0] d);
      check("idle_ready", {31'd0, s_slave_ready}, 32'd1);
      s_master_valid = 1'b1;
      s_read_en      = !wr;
      s_write_en     = wr;
      s_rx_address   = a[0];
      s_rx_burst     = b[0];
      s_slave_delay  = d;
      cyc();
      check("busy_ready", {31'd0, s_slave_ready}, 32'd0);
      for (int i = 1; i < AW; i++) begin
         gap();
         s_master_valid = 1'b1;
         s_rx_address   = a[i];
         s_rx_burst     = b[i];
         s_read_en      = 1'($urandom_range(0, 1));
         s_write_en     = 1'($urandom_range(0, 1));
         s_slave_delay  = 6'($urandom_range(0, 63));
         cyc();
      end
      s_master_valid = 1'b0;
      s_read_en      = 1'b0;
      s_write_en     = 1'b0;
   endtask

   task automatic write_txn(input logic [AW-1:0] a, input logic [BW-1:0] b);
      int n;
      n = (b == 0) ? 1 : int'(b);
      start_txn(1'b1, a, b, 6'($urandom_range(0, 63)));
      for (int k = 0; k < n; k++) begin
         for (int j = 0; j < DW; j++) begin
            gap();
            s_master_valid = 1'b1;
            s_rx_data      = wbuf[k][j];
            s_read_en      = 1'($urandom_range(0, 1));
            s_write_en     = 1'($urandom_range(0, 1));
            cyc();
         end
      end
      s_master_valid = 1'b0;
      s_read_en      = 1'b0;
      s_write_en     = 1'b0;
      check("wr_done_ready", {31'd0, s_slave_ready}, 32'd1);
      for (int k = 0; k < n; k++) ref_mem[(int'(a) + k) % DEPTH] = wbuf[k];
   endtask

   // mode 0: always ready, 1: ready every other cycle, 2: random ready
   task automatic read_txn(input logic [AW-1:0] a, input logic [BW-1:0] b, input int mode,
                           input logic [5:0] d);
      int   n, lat, exp_lat, got, guard;
      logic pv, pt, pr, r, tog;
      n = (b == 0) ? 1 : int'(b);
`ifdef BRAM_SLAVE_DELAY_EN
      exp_lat = (d == 0) ? 1 : 1 + int'(d);
`else
      exp_lat = 1;
`endif
      start_txn(1'b0, a, b, d);
      lat = 0;
      while (!s_slave_valid && lat < 200) begin
         cyc();
         lat++;
      end
      check("first_valid_lat", lat, exp_lat);
      got = 0; guard = 0; pv = 0; pt = 0; pr = 0; tog = 0;
      while (got < n * DW && guard < 4000) begin
         if (pv && !pr) check("hold_bit", {30'd0, s_slave_valid, s_tx_data}, {30'd0, 1'b1, pt});
         case (mode)
            0:       r = 1'b1;
            1:       r = tog;
            default: r = 1'($urandom_range(0, 1));
         endcase
         tog = !tog;
         s_master_ready = r;
         if (s_slave_valid && r) begin
            bits_q[got] = s_tx_data;
            got++;
         end
         pv = s_slave_valid; pt = s_tx_data; pr = r;
         cyc();
         guard++;
      end
      s_master_ready = 1'b0;
      check("rd_bit_count", got, n * DW);
      check("rd_done_ready", {31'd0, s_slave_ready}, 32'd1);
      check("rd_done_valid", {31'd0, s_slave_valid}, 32'd0);
      for (int k = 0; k < n; k++) begin
         logic [DW-1:0] w;
         for (int j = 0; j < DW; j++) w[j] = bits_q[k * DW + j];
         check("rd_word", {24'd0, w}, {24'd0, ref_mem[(int'(a) + k) % DEPTH]});
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, {31'd0, s_slave_ready}, 32'd1);
      check({tag, "_valid"}, {31'd0, s_slave_valid}, 32'd0);
      check({tag, "_tx"},    {31'd0, s_tx_data},     32'd0);
      check({tag, "_split"}, {31'd0, s_split_en},    32'd0);
   endtask

   initial begin
      int g;
      #2 rst = 1'b0;
      #1 check_reset_outputs("por");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      cyc();

      // single word, then readback
      wbuf[0] = 8'hA5;
      write_txn(12'h005, 12'd1);
      read_txn(12'h005, 12'd1, 0, 6'd0);
      check("a5_literal", {24'd0, ref_mem[5]}, 32'h0000_00A5);

      // burst across the top of the address space
      wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
      write_txn(12'hFFF, 12'd3);
      read_txn(12'hFFF, 12'd3, 2, 6'd0);
      read_txn(12'h000, 12'd1, 0, 6'd0);
      read_txn(12'h001, 12'd0, 0, 6'd0);

      // master ready every other cycle
      read_txn(12'h005, 12'd1, 1, 6'd0);

      // read latency with a delay request
      read_txn(12'h005, 12'd1, 0, 6'd5);

      // reset in the middle of a write data phase
      wbuf[0] = 8'h77;
      write_txn(12'h010, 12'd1);
      start_txn(1'b1, 12'h010, 12'd1, 6'd0);
      for (int j = 0; j < 4; j++) begin
         s_master_valid = 1'b1;
         s_rx_data      = 1'b1;
         cyc();
      end
      check("pre_rst_ready", {31'd0, s_slave_ready}, 32'd0);
      rst = 1'b0;
      #1 check_reset_outputs("mid_wr_rst");
      s_master_valid = 1'b0;
      s_rx_data      = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      cyc();
      read_txn(12'h010, 12'd1, 0, 6'd0);

      // reset while read data is being presented
      start_txn(1'b0, 12'h010, 12'd1, 6'd0);
      g = 0;
      while (!s_slave_valid && g < 100) begin
         cyc();
         g++;
      end
      check("pre_rst_valid", {31'd0, s_slave_valid}, 32'd1);
      rst = 1'b0;
      #1 check_reset_outputs("mid_rd_rst");
      @(negedge clk);
      rst = 1'b1;
      cyc();

      // conflicting or missing qualifiers do not start anything
      s_master_valid = 1'b1;
      s_read_en      = 1'b1;
      s_write_en     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("both_en_ready", {31'd0, s_slave_ready}, 32'd1);
      end
      s_read_en  = 1'b0;
      s_write_en = 1'b0;
      cyc();
      check("no_en_ready", {31'd0, s_slave_ready}, 32'd1);
      s_master_valid = 1'b0;
      cyc();
      read_txn(12'h010, 12'd1, 2, 6'd0);

      // randomized bursts against the model
      for (int it = 0; it < 8; it++) begin
         logic [AW-1:0] a;
         logic [BW-1:0] b;
         a = AW'($urandom_range(0, DEPTH - 1));
         if (it == 0) a = 12'hFFE;
         b = BW'($urandom_range(0, 4));
         for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom_range(0, 255));
         write_txn(a, b);
         read_txn(a, b, $urandom_range(0, 2), 6'($urandom_range(0, 7)));
      end
      check("split_final", {31'd0, s_split_en}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
